// File: rtl/bram_stream_pkg.sv
// Shared types and constants for the BRAM stream reader.
package bram_stream_pkg;

  // Reader control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Output FIFO depth used when the instantiating code does not override it.
  localparam int DEFAULT_DEPTH = 4;

endpackage

// File: rtl/bram_stream_reader_fifo.sv
// Small synchronous FIFO buffering words returned from the BRAM.
// Storage is not reset; only pointers and the occupancy count are.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop against full/empty so the pointers can never run past each other.
  always_comb begin
    do_push_s = push && (count_r != CNT_W'(DEPTH));
    do_pop_s  = pop && (count_r != CNT_W'(0));
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO synchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else if (flush) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Data storage write port; contents need no reset.
  always_ff @(posedge clock) begin
    if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign empty = (count_r == CNT_W'(0));
  assign count = count_r;

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a block of words from a 1-cycle-latency BRAM port and streams them
// out through a credit-controlled FIFO with valid/ready handshake.
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_q,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W:0] REM_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W:0]   remaining_r;
  logic              inflight_r;
  logic              busy_r;
  logic              done_r;

  logic [CNT_W-1:0]  fifo_count_s;
  logic              fifo_empty_s;
  logic              credit_ok_s;
  logic              rd_issue_s;
  logic              start_act_s;
  logic              abort_act_s;
  logic              push_s;
  logic              pop_s;
  logic              finish_s;

  // Qualified command, credit and datapath strobes.
  always_comb begin
    start_act_s = start && (state_r == IDLE);
    abort_act_s = abort && (state_r != IDLE);
    // Occupied slots plus the word still in the BRAM pipeline must leave room.
    credit_ok_s = (fifo_count_s + CNT_W'(inflight_r)) < CNT_W'(DEPTH);
    // A read issued in the abort cycle would be discarded anyway, so suppress it.
    rd_issue_s  = (state_r == FETCH) && (remaining_r != REM_ZERO) && credit_ok_s && !abort;
    push_s      = inflight_r && !abort_act_s;
    pop_s       = !fifo_empty_s && out_ready;
    finish_s    = (state_r == DRAIN) && !inflight_r && fifo_empty_s && !abort;
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && (length != REM_ZERO)) begin
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (abort) begin
          state_s = IDLE;
        end else if ((remaining_r == REM_ZERO) || (rd_issue_s && (remaining_r == REM_ONE))) begin
          state_s = DRAIN;
        end else begin
          state_s = FETCH;
        end
      end
      DRAIN: begin
        if (abort || finish_s) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register plus registered busy/done status.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (start_act_s && (length == REM_ZERO)) || finish_s;
    end
  end

  // Address and remaining-word counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_r      <= {ADDR_W{1'b0}};
      remaining_r <= REM_ZERO;
    end else if (start_act_s && (length != REM_ZERO)) begin
      addr_r      <= start_addr;
      remaining_r <= length;
    end else if (abort_act_s) begin
      addr_r      <= addr_r;
      remaining_r <= REM_ZERO;
    end else if (rd_issue_s) begin
      addr_r      <= addr_r + ADDR_W'(1);
      remaining_r <= remaining_r - REM_ONE;
    end else begin
      addr_r      <= addr_r;
      remaining_r <= remaining_r;
    end
  end

  // Marks that mem_q carries a requested word on the following cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= rd_issue_s;
    end
  end

  stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push_s),
    .push_data (mem_q),
    .pop       (pop_s),
    .flush     (abort_act_s),
    .head      (out_data),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign mem_rd    = rd_issue_s;
  assign mem_addr  = addr_r;
  assign out_valid = !fifo_empty_s;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed scoreboard bench for bram_stream_reader.
module tb_bram_stream_reader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  start_addr = 10'h000;
  logic [10:0] length = 11'd0;
  logic        abort = 1'b0;
  logic        mem_rd;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_q = 8'h00;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  logic [7:0]  exp_q[$];
  logic [9:0]  addr_log[$];
  int rd_cnt = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_pop_cyc = -1;
  int first_pop_cyc = -1;
  int first_valid_cyc = -1;
  int start_cyc = 0;

  bram_stream_reader #(.WIDTH(8), .ADDR_W(10), .DEPTH(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .abort      (abort),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_q      (mem_q),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // BRAM model: mem[i] = i[7:0]; junk when no read was issued.
  always @(posedge clock) mem_q <= mem_rd ? mem_addr[7:0] : 8'hEE;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: scoreboard pops on every handshake, plus event bookkeeping.
  always @(negedge clock) begin
    if (reset_n) begin
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL word_unexpected: got 0x%0h expected none", out_data);
        end else begin
          check("word", int'(out_data), int'(exp_q.pop_front()));
        end
        pop_cnt++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
      end
      if (mem_rd) begin
        rd_cnt++;
        addr_log.push_back(mem_addr);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_stats();
    rd_cnt = 0; pop_cnt = 0; done_cnt = 0; done_cyc = -1;
    last_pop_cyc = -1; first_pop_cyc = -1; first_valid_cyc = -1;
    addr_log.delete();
  endtask

  // Queue expected words and pulse start for one cycle.
  task automatic issue(input logic [9:0] a, input int len);
    for (int i = 0; i < len; i++) begin
      logic [9:0] ad;
      ad = a + 10'(i);
      exp_q.push_back(ad[7:0]);
    end
    clear_stats();
    @(posedge clock); #1;
    start_cyc = cyc;
    start = 1'b1; start_addr = a; length = 11'(len);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    bit got;
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (done) begin got = 1'b1; break; end
    end
    check(name, int'(got), 1);
    @(negedge clock);
  endtask

  initial begin
    // Reset values
    #2;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_mem_rd", int'(mem_rd), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Basic transfer
    out_ready = 1'b1;
    issue(10'h010, 8);
    wait_done("basic_done_seen", 60);
    check("basic_pops", pop_cnt, 8);
    check("basic_left", exp_q.size(), 0);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_latency", first_valid_cyc, start_cyc + 3);
    check("basic_sustain", last_pop_cyc - first_pop_cyc, 7);
    check("basic_done_after_pop", done_cyc, last_pop_cyc + 2);
    check("basic_busy_end", int'(busy), 0);

    // Address wrap
    issue(10'h3FE, 4);
    wait_done("wrap_done_seen", 60);
    check("wrap_rd_cnt", rd_cnt, 4);
    check("wrap_addr0", (addr_log.size() > 0) ? int'(addr_log[0]) : -1, 'h3FE);
    check("wrap_addr1", (addr_log.size() > 1) ? int'(addr_log[1]) : -1, 'h3FF);
    check("wrap_addr2", (addr_log.size() > 2) ? int'(addr_log[2]) : -1, 'h000);
    check("wrap_addr3", (addr_log.size() > 3) ? int'(addr_log[3]) : -1, 'h001);
    check("wrap_left", exp_q.size(), 0);

    // Backpressure
    out_ready = 1'b0;
    issue(10'h020, 16);
    repeat (20) @(negedge clock);
    check("bp_rd_blocked", rd_cnt, 4);
    check("bp_valid_blocked", int'(out_valid), 1);
    check("bp_busy_blocked", int'(busy), 1);
    out_ready = 1'b1;
    wait_done("bp_done_seen", 100);
    check("bp_pops", pop_cnt, 16);
    check("bp_left", exp_q.size(), 0);

    // Zero length
    issue(10'h030, 0);
    @(negedge clock);
    check("zero_done", int'(done), 1);
    check("zero_busy", int'(busy), 0);
    @(negedge clock);
    check("zero_done_pulse", int'(done), 0);
    check("zero_busy2", int'(busy), 0);
    repeat (3) @(negedge clock);
    check("zero_rd_cnt", rd_cnt, 0);
    check("zero_done_cnt", done_cnt, 1);

    // Abort on the third FETCH cycle
    issue(10'h040, 10);
    @(posedge clock); #1;
    @(posedge clock); #1;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(out_valid), 0);
    check("abort_pops", pop_cnt, 1);
    exp_q.delete();
    repeat (4) @(negedge clock);
    check("abort_no_done", done_cnt, 0);
    check("abort_valid_later", int'(out_valid), 0);
    issue(10'h050, 2);
    wait_done("post_abort_done_seen", 40);
    check("post_abort_pops", pop_cnt, 2);
    check("post_abort_left", exp_q.size(), 0);

    // Reset with three words buffered
    out_ready = 1'b0;
    issue(10'h060, 8);
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mrst_busy", int'(busy), 0);
    check("mrst_done", int'(done), 0);
    check("mrst_mem_rd", int'(mem_rd), 0);
    check("mrst_out_valid", int'(out_valid), 0);
    check("mrst_mem_addr", int'(mem_addr), 0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    for (int i = 0; i < 3; i++) exp_q.push_back(8'h70 + 8'(i));
    clear_stats();
    reset_n = 1'b1;
    out_ready = 1'b1;
    start = 1'b1; start_addr = 10'h070; length = 11'd3;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done("post_rst_done_seen", 40);
    check("post_rst_pops", pop_cnt, 3);
    check("post_rst_left", exp_q.size(), 0);
    check("post_rst_done_cnt", done_cnt, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 Parameters SHALL be:
  - WIDTH, default 8, data word width.
  - ADDR_W, default 10, memory address width.
  - DEPTH, default 4, output FIFO depth (power of two, at least 2).
REQ-002 Ports SHALL be, clock and reset first:
  - clock  in  1  single clock.
  - reset_n  in  1  asynchronous active-low reset.
REQ-003 Command ports SHALL be:
  - start  in  1  one-cycle request to begin a transfer.
  - start_addr  in  ADDR_W  first address to read.
  - length  in  ADDR_W+1  number of words to read (0 is legal).
  - abort  in  1  cancels the transfer in progress.
REQ-004 Memory-side ports (drive a dual-port BRAM read port, 1-cycle registered read) SHALL be:
  - mem_rd  out  1  read issue strobe.
  - mem_addr  out  ADDR_W  read address.
  - mem_q  in  WIDTH  read data, valid exactly one cycle after mem_rd.
REQ-005 Stream and status ports SHALL be:
  - out_valid  out  1  output word available.
  - out_data  out  WIDTH  output word.
  - out_ready  in  1  consumer accepts the word.
  - busy  out  1  transfer active.
  - done  out  1  one-cycle completion pulse.
REQ-006 Reset SHALL be asynchronous and active-low on reset_n; the block SHALL use the single clock "clock".

Function
REQ-007 The state machine SHALL have three states: IDLE, FETCH, DRAIN.
REQ-008 In IDLE, start with length>0 SHALL do all of the following:
  - load the address counter with start_addr;
  - load the remaining count with length;
  - enter FETCH;
  - raise busy on the next cycle.
REQ-009 In IDLE, start with length==0 SHALL pulse done on the next cycle, issue no reads, and stay in IDLE.
REQ-010 While busy, start SHALL be ignored.
REQ-011 In FETCH, mem_rd SHALL assert when remaining>0 and (fifo_count + inflight) < DEPTH. This is a credit rule: the FIFO never overflows.
REQ-012 Each mem_rd SHALL present the current address; the address SHALL increment modulo 2**ADDR_W (0x3FF wraps to 0x000) and remaining SHALL decrement.
REQ-013 mem_q SHALL be written into the FIFO on the cycle after mem_rd (the inflight flag). No other data SHALL be captured.
REQ-014 When remaining reaches 0, the FSM SHALL enter DRAIN.
REQ-015 DRAIN SHALL wait until inflight==0 and the FIFO is empty, then pulse done for one cycle, return to IDLE and drop busy in the same cycle.
REQ-016 out_valid SHALL equal FIFO not-empty; out_data SHALL be the FIFO head; a word SHALL pop when out_valid && out_ready.
REQ-017 A simultaneous push and pop SHALL leave fifo_count unchanged. A pop with out_ready held high SHALL sustain one word per clock after a 2-cycle startup latency from start.
REQ-018 abort in FETCH or DRAIN SHALL, at the next edge:
  - flush the FIFO;
  - discard any inflight return;
  - clear remaining;
  - return to IDLE with busy low and no done pulse.
  abort in IDLE SHALL have no effect.
REQ-019 If abort and start are asserted in the same cycle while IDLE, start SHALL win.
REQ-020 Word order at out_data SHALL equal address order. Words SHALL never be duplicated or dropped except by abort.

Reset
REQ-021 On reset_n low, all of the following SHALL be cleared immediately, regardless of clock:
  - state = IDLE;
  - busy, done, mem_rd and out_valid = 0;
  - mem_addr = 0, remaining = 0, fifo_count = 0, inflight = 0.
REQ-022 A reset asserted mid-transfer SHALL discard all state. After release, the block SHALL accept a new start on the first clock edge.
REQ-023 FIFO storage contents SHALL need no reset; only the pointers and count are reset.

Structure
REQ-024 Package bram_stream_pkg SHALL hold the state enum (IDLE, FETCH, DRAIN) and the constant for the default DEPTH.
REQ-025 The FIFO SHALL be a sub-module named stream_fifo, with these features:
  - parameters WIDTH and DEPTH;
  - push, pop, flush, empty and count ports;
  - synchronous flush;
  - asynchronous active-low reset on reset_n.
REQ-026 The FSM, address counter, remaining counter and credit logic SHALL live in bram_stream_reader.

Verification
REQ-027 Basic transfer: memory preloaded mem[i]=i[7:0]; start_addr=0x010, length=8, out_ready=1.
  - out_data SHALL be 0x10..0x17 in order.
  - done SHALL pulse once, one cycle after the last pop.
REQ-028 Wrap: start_addr=0x3FE, length=4. mem_addr SHALL sequence 0x3FE, 0x3FF, 0x000, 0x001.
REQ-029 Backpressure: length=16 with out_ready held low for 20 cycles, then released.
  - No more than 4 mem_rd SHALL occur while blocked.
  - All 16 words SHALL arrive in order.
REQ-030 Zero length: start with length=0.
  - done SHALL pulse on the next cycle.
  - mem_rd SHALL never assert.
  - busy SHALL stay 0.
REQ-031 Abort: abort on the 3rd FETCH cycle of a length=10 transfer.
  - busy=0 and out_valid=0 next cycle.
  - No done pulse.
  - A following start with length=2 SHALL return the correct two words.
REQ-032 Reset mid-transfer: reset_n pulsed low during a length=8 transfer with 3 words buffered.
  - All outputs SHALL go to their reset values asynchronously.
  - A subsequent transfer SHALL complete correctly.
